// File: rtl/blob_pkg.sv
// rtl/blob_pkg.sv - shared blob box constants, packing helpers and tx state encoding
package blob_pkg;

  localparam int MAX_OBJ_NUM = 15;
  localparam int H_BITS      = 10;
  localparam int V_BITS      = 9;
  localparam int BOX_BS      = 2 * (H_BITS + V_BITS);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // A box goes on the wire as a 40-bit record, zero-padded above the box bits.
  localparam int REC_BYTES = 5;
  localparam int REC_BITS  = 8 * REC_BYTES;

  localparam int SLOT_W = $clog2(MAX_OBJ_NUM);
  localparam int CNT_W  = $clog2(MAX_OBJ_NUM + 1);

  typedef logic [BOX_BS-1:0] box_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    CNT,
    BOX,
    CHK
  } tx_state_t;

  // Packs one box as {top, bottom, left, right}, top in the MSBs.
  function automatic box_t pack_box(
    input logic [V_BITS-1:0] top,
    input logic [V_BITS-1:0] bottom,
    input logic [H_BITS-1:0] left,
    input logic [H_BITS-1:0] right
  );
    return {top, bottom, left, right};
  endfunction

  // Byte idx (0 = most significant) of the padded record for one box.
  function automatic logic [7:0] record_byte(input box_t b, input logic [2:0] idx);
    logic [REC_BITS-1:0] w;
    w = {{(REC_BITS - BOX_BS){1'b0}}, b};
    return w[8 * (REC_BYTES - 1 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/blob_box_tx_if.sv
// rtl/blob_box_tx_if.sv - valid/ready byte stream toward the link transmitter
interface blob_box_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/blob_box_tx_lowest_set_index.sv
// rtl/blob_box_tx_lowest_set_index.sv - priority encoder: index of lowest set mask bit
module lowest_set_index #(
  parameter int WIDTH = 15,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = |mask;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/blob_box_tx.sv
// rtl/blob_box_tx.sv - per-frame snapshot of the box table, serialized as a framed byte packet
module blob_box_tx
  import blob_pkg::*;
(
  input  logic                          app_clk,
  input  logic                          app_rst,
  input  logic                          frame_done,
  input  logic [MAX_OBJ_NUM*BOX_BS-1:0] boxes,
  input  logic [MAX_OBJ_NUM-1:0]        box_valid,
  blob_box_tx_if.master                 tx,
  output logic                          busy,
  output logic [7:0]                    drop_count
);

  tx_state_t              state_q, state_n;
  box_t                   snap_q [MAX_OBJ_NUM];
  logic [MAX_OBJ_NUM-1:0] remaining_q, remaining_n;
  logic [CNT_W-1:0]       count_q, count_n;
  logic [SLOT_W-1:0]      slot_q, slot_n;
  logic [2:0]             byte_idx_q, byte_idx_n;
  logic [7:0]             sum_q, sum_n;
  logic [7:0]             seq_q, seq_n;
  logic [7:0]             data_q, data_n;
  logic                   valid_q, valid_n;
  logic                   busy_q, busy_n;
  logic [7:0]             drop_q, drop_n;
  logic                   latch_en;

  logic                   accept;
  logic [CNT_W-1:0]       pop_count;
  logic [MAX_OBJ_NUM-1:0] clear_mask;
  logic [MAX_OBJ_NUM-1:0] enc_in;
  logic [SLOT_W-1:0]      next_slot;
  logic                   next_any;
  box_t                   cur_box;
  box_t                   next_box;

  assign accept  = valid_q && tx.tx_ready;
  assign cur_box = snap_q[slot_q];

  // The slot being sent is removed from the mask as its last byte leaves;
  // in CNT nothing has been sent yet, so the whole mask is searched.
  assign clear_mask = remaining_q & ~(MAX_OBJ_NUM'(1) << slot_q);
  assign enc_in     = (state_q == CNT) ? remaining_q : clear_mask;
  assign next_box   = snap_q[next_slot];

  lowest_set_index #(
    .WIDTH (MAX_OBJ_NUM),
    .IDX_W (SLOT_W)
  ) u_next_slot (
    .mask  (enc_in),
    .index (next_slot),
    .any   (next_any)
  );

  // Number of live boxes in the incoming table, latched as N.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < MAX_OBJ_NUM; i++) begin
      pop_count = pop_count + CNT_W'(box_valid[i]);
    end
  end

  // Next state and next output byte; the byte after the one being accepted is
  // prepared here so tx_data can stay registered with no bubbles.
  always_comb begin
    state_n     = state_q;
    remaining_n = remaining_q;
    count_n     = count_q;
    slot_n      = slot_q;
    byte_idx_n  = byte_idx_q;
    sum_n       = sum_q;
    seq_n       = seq_q;
    data_n      = data_q;
    valid_n     = valid_q;
    busy_n      = busy_q;
    drop_n      = drop_q;
    latch_en    = 1'b0;

    // A pulse that lands while busy (including the CHK acceptance cycle) is lost.
    if (frame_done && busy_q && (drop_q != 8'hFF)) begin
      drop_n = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (frame_done) begin
          latch_en    = 1'b1;
          remaining_n = box_valid;
          count_n     = pop_count;
          sum_n       = '0;
          data_n      = SYNC_BYTE;
          valid_n     = 1'b1;
          busy_n      = 1'b1;
          state_n     = SYNC;
        end
      end
      SYNC: begin
        if (accept) begin
          data_n  = seq_q;
          state_n = SEQ;
        end
      end
      SEQ: begin
        if (accept) begin
          sum_n   = sum_q + data_q;
          data_n  = {{(8 - CNT_W){1'b0}}, count_q};
          state_n = CNT;
        end
      end
      CNT: begin
        if (accept) begin
          sum_n = sum_q + data_q;
          if (count_q != '0) begin
            slot_n     = next_slot;
            byte_idx_n = 3'd0;
            data_n     = record_byte(next_box, 3'd0);
            state_n    = BOX;
          end else begin
            data_n  = sum_q + data_q;
            state_n = CHK;
          end
        end
      end
      BOX: begin
        if (accept) begin
          sum_n = sum_q + data_q;
          if (byte_idx_q != 3'(REC_BYTES - 1)) begin
            byte_idx_n = byte_idx_q + 3'd1;
            data_n     = record_byte(cur_box, byte_idx_q + 3'd1);
          end else begin
            remaining_n = clear_mask;
            byte_idx_n  = 3'd0;
            if (next_any) begin
              slot_n = next_slot;
              data_n = record_byte(next_box, 3'd0);
            end else begin
              data_n  = sum_q + data_q;
              state_n = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          seq_n   = seq_q + 8'd1;
          data_n  = 8'h00;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset abandons any packet in flight.
  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      slot_q      <= '0;
      byte_idx_q  <= '0;
      sum_q       <= '0;
      seq_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_n;
      remaining_q <= remaining_n;
      count_q     <= count_n;
      slot_q      <= slot_n;
      byte_idx_q  <= byte_idx_n;
      sum_q       <= sum_n;
      seq_q       <= seq_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
      busy_q      <= busy_n;
      drop_q      <= drop_n;
    end
  end

  // Box snapshot, taken only on the frame_done that starts a packet.
  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      for (int i = 0; i < MAX_OBJ_NUM; i++) begin
        snap_q[i] <= '0;
      end
    end else if (latch_en) begin
      for (int i = 0; i < MAX_OBJ_NUM; i++) begin
        snap_q[i] <= boxes[i*BOX_BS +: BOX_BS];
      end
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_blob_box_tx.sv
// tb/tb_blob_box_tx.sv - self-checking bench for blob_box_tx
module tb_blob_box_tx;
  import blob_pkg::*;

  typedef logic [MAX_OBJ_NUM*BOX_BS-1:0] boxes_vec_t;
  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [14:0] mask;
    bit          rnd;
    int          exp_len;
    logic [7:0]  exp_n;
  } vec_t;

  logic        app_clk = 1'b0;
  logic        app_rst;
  logic        frame_done;
  boxes_vec_t  boxes;
  logic [14:0] box_valid;
  logic        busy;
  logic [7:0]  drop_count;

  blob_box_tx_if tx_bus();

  blob_box_tx dut (
    .app_clk    (app_clk),
    .app_rst    (app_rst),
    .frame_done (frame_done),
    .boxes      (boxes),
    .box_valid  (box_valid),
    .tx         (tx_bus),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 app_clk = ~app_clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] seq_m    = 8'd0;

  task automatic step();
    @(posedge app_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic boxes_vec_t rand_boxes();
    boxes_vec_t r;
    for (int i = 0; i < MAX_OBJ_NUM; i++) begin
      r[i*BOX_BS +: BOX_BS] = pack_box(9'($urandom), 9'($urandom), 10'($urandom), 10'($urandom));
    end
    return r;
  endfunction

  // Reference packet built straight from the framing rules.
  function automatic bq_t make_pkt(input boxes_vec_t b, input logic [14:0] m, input logic [7:0] s);
    bq_t q;
    int n;
    int sum;
    logic [39:0] w;
    q = {};
    n = 0;
    for (int i = 0; i < 15; i++) if (m[i]) n++;
    q.push_back(8'hA5);
    q.push_back(s);
    q.push_back(8'(n));
    for (int i = 0; i < 15; i++) begin
      if (m[i]) begin
        w = {2'b00, b[i*BOX_BS +: BOX_BS]};
        for (int k = 0; k < 5; k++) q.push_back(w[39 - 8*k -: 8]);
      end
    end
    sum = 0;
    for (int i = 1; i < q.size(); i++) sum += int'(q[i]);
    q.push_back(8'(sum));
    return q;
  endfunction

  task automatic run_packet(input boxes_vec_t b, input logic [14:0] m, input bit rnd,
                            input string tag, output bq_t got);
    bq_t exp;
    int cyc;
    bit stall;
    logic [7:0] pdata;
    exp = make_pkt(b, m, seq_m);
    boxes = b;
    box_valid = m;
    frame_done = 1'b1;
    tx_bus.tx_ready = 1'b1;
    step();
    frame_done = 1'b0;
    boxes = rand_boxes();
    box_valid = 15'($urandom);
    check({tag, "_first_valid"}, 32'(tx_bus.tx_valid), 32'd1);
    check({tag, "_first_busy"}, 32'(busy), 32'd1);
    check({tag, "_first_sync"}, 32'(tx_bus.tx_data), 32'hA5);
    got = {};
    cyc = 0;
    stall = 1'b0;
    pdata = 8'h00;
    while (got.size() < exp.size() && cyc < 4000) begin
      if (stall) begin
        check({tag, "_hold_valid"}, 32'(tx_bus.tx_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(tx_bus.tx_data), 32'(pdata));
      end
      tx_bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_bus.tx_valid && tx_bus.tx_ready) got.push_back(tx_bus.tx_data);
      stall = tx_bus.tx_valid && !tx_bus.tx_ready;
      pdata = tx_bus.tx_data;
      step();
      cyc++;
    end
    tx_bus.tx_ready = 1'b1;
    if (cyc >= 4000) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
    if (!rnd) check({tag, "_no_gaps"}, 32'(cyc), 32'(exp.size()));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_after"}, 32'(tx_bus.tx_valid), 32'd0);
    seq_m = seq_m + 8'd1;
  endtask

  initial begin
    vec_t       vecs[9];
    bq_t        g;
    bq_t        g2;
    bq_t        exp;
    bq_t        all_exp;
    bq_t        got_all;
    boxes_vec_t b;
    logic [7:0] hand[9];
    int         busy_end;
    int         start_k;
    int         drops;
    bit         mb;

    vecs = '{
      '{15'h0000, 1'b0,  4, 8'd0},
      '{15'h0008, 1'b0,  9, 8'd1},
      '{15'h4005, 1'b0, 19, 8'd3},
      '{15'h7FFF, 1'b0, 79, 8'd15},
      '{15'h4000, 1'b0,  9, 8'd1},
      '{15'h2AAA, 1'b0, 39, 8'd7},
      '{15'h5555, 1'b1, 44, 8'd8},
      '{15'h0124, 1'b1, 19, 8'd3},
      '{15'h7FFF, 1'b1, 79, 8'd15}
    };

    app_rst = 1'b1;
    frame_done = 1'b0;
    boxes = '0;
    box_valid = '0;
    tx_bus.tx_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(tx_bus.tx_valid), 32'd0);
    check("rst_data", 32'(tx_bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    app_rst = 1'b0;
    step();

    // Empty frame: hand-derived bytes.
    run_packet(rand_boxes(), 15'h0000, 1'b0, "empty", g);
    hand[0] = 8'hA5; hand[1] = 8'h00; hand[2] = 8'h00; hand[3] = 8'h00;
    for (int i = 0; i < 4 && i < g.size(); i++) check($sformatf("empty_hand%0d", i), 32'(g[i]), 32'(hand[i]));

    // Single box in slot 3, packet seq 1: hand-derived record and checksum.
    b = rand_boxes();
    b[3*BOX_BS +: BOX_BS] = pack_box(9'd5, 9'd20, 10'd100, 10'd200);
    run_packet(b, 15'h0008, 1'b0, "single", g);
    hand = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hA1, 8'h41, 8'h90, 8'hC8, 8'h3C};
    check("single_hand_len", 32'(g.size()), 32'd9);
    for (int i = 0; i < 9 && i < g.size(); i++) check($sformatf("single_hand%0d", i), 32'(g[i]), 32'(hand[i]));

    // Table of masks against the reference model.
    for (int v = 0; v < 9; v++) begin
      run_packet(rand_boxes(), vecs[v].mask, vecs[v].rnd, $sformatf("vec%0d", v), g);
      check($sformatf("vec%0d_tbl_len", v), 32'(g.size()), 32'(vecs[v].exp_len));
      if (g.size() > 2) check($sformatf("vec%0d_tbl_n", v), 32'(g[2]), 32'(vecs[v].exp_n));
    end

    // Backpressure: same 3-box table with and without random stalls.
    b = rand_boxes();
    run_packet(b, 15'h0A10, 1'b0, "bp_ref", g);
    run_packet(b, 15'h0A10, 1'b1, "bp_rnd", g2);
    check("bp_len_eq", 32'(g2.size()), 32'(g.size()));
    for (int i = 2; i + 1 < g.size() && i + 1 < g2.size(); i++) begin
      check($sformatf("bp_eq%0d", i), 32'(g2[i]), 32'(g[i]));
    end

    // Overrun: frame_done every 10 cycles, full table, timeline model.
    b = rand_boxes();
    boxes = b;
    box_valid = 15'h7FFF;
    tx_bus.tx_ready = 1'b1;
    busy_end = -1;
    start_k = -1;
    drops = 0;
    all_exp = {};
    got_all = {};
    for (int k = 0; k < 3400 || k <= busy_end + 1; k++) begin
      mb = (k > start_k) && (k <= busy_end);
      check("ovr_busy", 32'(busy), 32'(mb));
      if (tx_bus.tx_valid) got_all.push_back(tx_bus.tx_data);
      frame_done = (k < 3400) && (k % 10 == 0);
      if (frame_done) begin
        if (k > busy_end) begin
          exp = make_pkt(b, 15'h7FFF, seq_m);
          seq_m = seq_m + 8'd1;
          start_k = k;
          busy_end = k + exp.size();
          foreach (exp[j]) all_exp.push_back(exp[j]);
        end else begin
          drops++;
        end
      end
      step();
    end
    frame_done = 1'b0;
    check("ovr_len", 32'(got_all.size()), 32'(all_exp.size()));
    for (int i = 0; i < all_exp.size() && i < got_all.size(); i++) begin
      check($sformatf("ovr_byte%0d", i), 32'(got_all[i]), 32'(all_exp[i]));
    end
    check("ovr_drop_sat", 32'(drop_count), 32'((drops > 255) ? 255 : drops));

    // Reset after byte 2 of box 0 has been accepted.
    b = rand_boxes();
    exp = make_pkt(b, 15'h0003, seq_m);
    boxes = b;
    box_valid = 15'h0003;
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rstmid_pre_valid", 32'(tx_bus.tx_valid), 32'd1);
    check("rstmid_pre_data", 32'(tx_bus.tx_data), 32'(exp[6]));
    #2;
    app_rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(tx_bus.tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_data", 32'(tx_bus.tx_data), 32'd0);
    check("rstmid_drop", 32'(drop_count), 32'd0);
    step();
    app_rst = 1'b0;
    seq_m = 8'd0;
    step();
    run_packet(rand_boxes(), 15'h0000, 1'b0, "after_rst", g);
    if (g.size() > 1) check("after_rst_seq", 32'(g[1]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
